// File: rtl/fetch_unit_v_pkg.sv
// Shared types, constants and helpers for the fetch_unit_v instruction fetch stage.
// Optional zero-latency path is enabled by defining FETCH_BYPASS_EN.
package fetch_unit_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int          FETCH_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] PC_READ_OFFS    = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_v_fifo.sv
// Prefetch queue holding {pc, word} entries; flush drops all entries at once.
// Pops on an empty queue are ignored; the producer reserves slots so pushes never overflow.
module fetch_fifo_v
    import fetch_unit_v_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;

    // Qualify the pop so an empty queue never underflows.
    always_comb begin
        pop_ok_s = pop && (count_r != {CNT_W{1'b0}});
    end

    // Storage, pointers and occupancy; flush keeps stale data but empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'd0, word: 32'd0};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit_v.sv
// Instruction fetch stage: fetch PC, req/ack memory transaction and prefetch queue.
// Define FETCH_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module fetch_unit_v
    import fetch_unit_v_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus8,
    input  logic        instr_ready
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e     state_r;
    fetch_state_e     state_nxt_s;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      fetch_pc_nxt_s;
    logic [31:0]      addr_r;
    logic [31:0]      addr_nxt_s;
    logic             req_r;
    logic             req_nxt_s;

    logic             acc_s;
    logic             bypass_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_valid_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] count_after_pop_s;
    logic [CNT_W-1:0] count_after_push_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

    fetch_fifo_v #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect),
        .count      (count_s),
        .head       (head_s)
    );

    // Queue-side handshake: which response is kept and what decode takes this cycle.
    always_comb begin
        fifo_valid_s = (count_s != {CNT_W{1'b0}});
        acc_s        = (state_r == ST_REQ) && imem_ack;
`ifdef FETCH_BYPASS_EN
        bypass_s     = acc_s && !redirect && !fifo_valid_s;
`else
        bypass_s     = 1'b0;
`endif
        pop_s        = instr_ready && fifo_valid_s;
        push_s       = acc_s && !redirect && !(bypass_s && instr_ready);
        push_entry_s = '{pc: fetch_pc_r, word: imem_rdata};
        count_after_pop_s  = count_s - CNT_W'(pop_s);
        count_after_push_s = count_after_pop_s + CNT_W'(push_s);
    end

    // Fetch FSM: a request is only raised when a queue slot is reserved for its response.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        addr_nxt_s     = addr_r;
        req_nxt_s      = req_r;
        if (redirect) begin
            fetch_pc_nxt_s = align_pc(redirect_pc);
            if ((state_r != ST_IDLE) && !imem_ack) begin
                // Outstanding request keeps its address; its data is discarded later.
                state_nxt_s = ST_DRAIN;
            end else begin
                state_nxt_s = ST_REQ;
                req_nxt_s   = 1'b1;
                addr_nxt_s  = align_pc(redirect_pc);
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (count_after_pop_s < DEPTH_C) begin
                        state_nxt_s = ST_REQ;
                        req_nxt_s   = 1'b1;
                        addr_nxt_s  = fetch_pc_r;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
                        if (count_after_push_s < DEPTH_C) begin
                            state_nxt_s = ST_REQ;
                            req_nxt_s   = 1'b1;
                            addr_nxt_s  = fetch_pc_r + PC_STEP;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            req_nxt_s   = 1'b0;
                        end
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_nxt_s = ST_REQ;
                        req_nxt_s   = 1'b1;
                        addr_nxt_s  = fetch_pc_r;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM and bus registers; reset withdraws any request immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= align_pc(RESET_PC);
            addr_r     <= align_pc(RESET_PC);
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            addr_r     <= addr_nxt_s;
            req_r      <= req_nxt_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;

    // Decode-facing view of the queue head (or of the forwarded ack word).
    always_comb begin
`ifdef FETCH_BYPASS_EN
        if (bypass_s) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = fetch_pc_r;
        end else begin
            instr_valid = fifo_valid_s;
            instr       = head_s.word;
            instr_pc    = head_s.pc;
        end
`else
        instr_valid = fifo_valid_s;
        instr       = head_s.word;
        instr_pc    = head_s.pc;
`endif
        instr_pcplus8 = instr_pc + PC_READ_OFFS;
    end

endmodule

// File: tb/tb_fetch_unit_v.sv
// Self-checking bench for fetch_unit_v: directed scenarios then random memory/decode/redirect traffic
// checked against a stream-level model of the expected fetch and delivery order.
`timescale 1ns/1ps
module tb_fetch_unit_v;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus8;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;
    int consumed = 0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc8;

    logic [31:0] exp_pc, nf, pend_addr, redir_tgt;
    logic        stale, pend, lat, redir_chk, redir_issue, prev_rst;

    fetch_unit_v #(
        .DEPTH         (4),
        .RESET_PC      (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus8 (instr_pcplus8),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hE3A0_1005;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Stream-level model: fetch addresses and delivered instructions follow the program order.
    task automatic model_step(input logic rst, input logic ack, input logic rdy,
                              input logic rd, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = rpc & 32'hFFFF_FFFC;
        if (prev_rst) begin
            check("rst_req",   {31'd0, s_req},   32'd0);
            check("rst_addr",  s_addr,           RESET_PC);
            check("rst_valid", {31'd0, s_valid}, 32'd0);
            check("rst_instr", s_instr,          32'd0);
            check("rst_pc",    s_pc,             32'd0);
            check("rst_pc8",   s_pc8,            32'd8);
        end
        if (rst) begin
            exp_pc = RESET_PC; nf = RESET_PC;
            stale = 1'b0; pend = 1'b0; lat = 1'b0; redir_chk = 1'b0; redir_issue = 1'b0;
        end else begin
            if (pend) begin
                check("hold_req",  {31'd0, s_req}, 32'd1);
                check("hold_addr", s_addr, pend_addr);
            end
            if (redir_issue) begin
                check("redir_req",  {31'd0, s_req}, 32'd1);
                check("redir_addr", s_addr, redir_tgt);
            end
`ifndef FETCH_BYPASS_EN
            if (redir_chk) check("redir_flush", {31'd0, s_valid}, 32'd0);
            if (lat)       check("latency",     {31'd0, s_valid}, 32'd1);
`endif
            if (s_valid && rdy) begin
                check("instr_pc",   s_pc,    exp_pc);
                check("instr_word", s_instr, mem_word(exp_pc));
                check("instr_pc8",  s_pc8,   exp_pc + 32'd8);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            lat = 1'b0;
            if (s_req && ack && !rd && !stale) begin
                check("fetch_addr", s_addr, nf);
                nf  = nf + 32'd4;
                lat = 1'b1;
            end
            if (rd) stale = s_req && !ack;
            else if (s_req && ack) stale = 1'b0;
            redir_chk   = rd;
            redir_issue = rd && (!s_req || ack);
            redir_tgt   = tgt;
            if (rd) begin
                exp_pc = tgt;
                nf     = tgt;
            end
            pend      = s_req && !ack;
            pend_addr = s_addr;
        end
        prev_rst = rst;
    endtask

    task automatic cycle(input logic rst, input logic ack, input logic rdy,
                         input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        reset       = rst;
        imem_ack    = ack;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = mem_word(imem_addr);
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_pc8   = instr_pcplus8;
        model_step(rst, ack, rdy, rd, rpc);
    endtask

    initial begin
        int nv;
        logic        r_ack, r_rdy, r_rd, r_rst;
        logic [31:0] r_pc;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
        redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
        prev_rst = 1'b0; exp_pc = RESET_PC; nf = RESET_PC; pend_addr = 32'd0; redir_tgt = 32'd0;
        stale = 1'b0; pend = 1'b0; lat = 1'b0; redir_chk = 1'b0; redir_issue = 1'b0;

        // Reset values and first request.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("first_req",  {31'd0, s_req}, 32'd1);
        check("first_addr", s_addr, RESET_PC);

        // Streaming at one instruction per cycle.
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            if (i >= 10 && s_valid) nv++;
        end
        check("throughput", 32'(nv), 32'd20);

        // Backpressure fills the queue and stops requests; release resumes in order.
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("full_req_drop", {31'd0, s_req},   32'd0);
        check("full_valid",    {31'd0, s_valid}, 32'd1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect while a request waits: address held, data dropped, then refetch at target.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        check("wait_req", {31'd0, s_req}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("drain_addr", s_addr, RESET_PC);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("after_drain_req",  {31'd0, s_req}, 32'd1);
        check("after_drain_addr", s_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect in the same cycle as the ack of 0x10.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check("ack_redir_addr", s_addr, 32'h0000_0010);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("ack_redir_next", s_addr, 32'h0000_0200);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        check("redir_head_valid", {31'd0, s_valid}, 32'd1);
        check("redir_head_pc",    s_pc, 32'h0000_0200);

        // Reset in REQ with two queued entries.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("two_queued_valid", {31'd0, s_valid}, 32'd1);
        check("two_queued_req",   {31'd0, s_req},   32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("post_reset_req",  {31'd0, s_req}, 32'd1);
        check("post_reset_addr", s_addr, RESET_PC);

`ifdef FETCH_BYPASS_EN
        // Empty queue: the acked word is visible in the ack cycle.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("bypass_valid", {31'd0, s_valid}, 32'd1);
        check("bypass_instr", s_instr, 32'hE3A0_1005);
`endif

        // Random traffic, including unaligned targets and targets near the top of memory.
        for (int i = 0; i < 3000; i++) begin
            r_ack = ($urandom_range(0, 9) < 6);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_rd  = ($urandom_range(0, 99) < 3);
            r_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFE0 | ($urandom & 32'h0000_001F);
            else                           r_pc = $urandom & 32'h0000_FFFF;
            cycle(r_rst, r_ack, r_rdy, r_rd, r_pc);
        end
        check("progress", {31'd0, (consumed > 500)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
